// File: rtl/debounce_edge_counter_pkg.sv
// Shared definitions for the debounce / edge-counter block.
//   db_state_t      : debounce FSM state encoding
//   DEF_DB_CYCLES   : default number of identical samples to accept a change
//   DEF_CNT_W       : default width of the rising-edge event counter
package debounce_edge_counter_pkg;

    typedef enum logic [1:0] {
        S_LOW  = 2'd0,  // stable low
        P_HIGH = 2'd1,  // pending low->high, counting samples
        S_HIGH = 2'd2,  // stable high
        P_LOW  = 2'd3   // pending high->low, counting samples
    } db_state_t;

    localparam int DEF_DB_CYCLES = 4;
    localparam int DEF_CNT_W     = 8;

endpackage

// File: rtl/debounce_edge_counter_sat_counter.sv
// Saturating event counter with sticky overflow.
// Ports:
//   clk      : rising-edge clock
//   reset    : asynchronous active-low reset
//   inc      : count one event on this edge
//   clear    : synchronous clear; applied before inc on the same edge
//   count    : event count, holds at all-ones
//   overflow : sticky, set by an event arriving while count is all-ones
module sat_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             clear,
    output logic [CNT_W-1:0] count,
    output logic             overflow
);

    logic [CNT_W-1:0] count_q, count_d;
    logic             overflow_q, overflow_d;

    always_comb begin
        count_d    = count_q;
        overflow_d = overflow_q;
        if (clear) begin
            // Clear wins first; an event on the same edge then counts from zero.
            count_d    = inc ? CNT_W'(1) : '0;
            overflow_d = 1'b0;
        end else if (inc) begin
            if (&count_q) begin
                overflow_d = 1'b1;
            end else begin
                count_d = count_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    assign count    = count_q;
    assign overflow = overflow_q;

endmodule

// File: rtl/debounce_edge_counter.sv
// Debounces a synchronized input, emits a clean level with one-cycle
// rise/fall pulses, and counts debounced rising edges.
// Ports:
//   clk        : rising-edge clock (same domain as upstream synchronizer)
//   reset      : asynchronous active-low reset
//   din        : synchronized input
//   clear      : synchronous clear of count and overflow
//   level      : debounced level
//   rise_pulse : one-cycle pulse on an accepted 0->1 change
//   fall_pulse : one-cycle pulse on an accepted 1->0 change
//   count      : saturating count of accepted rising edges
//   overflow   : sticky, a rise arrived while count was all-ones
//   state_dbg  : current debounce FSM state
module debounce_edge_counter
    import debounce_edge_counter_pkg::*;
#(
    parameter int DB_CYCLES = DEF_DB_CYCLES,
    parameter int CNT_W     = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             din,
    input  logic             clear,
    output logic             level,
    output logic             rise_pulse,
    output logic             fall_pulse,
    output logic [CNT_W-1:0] count,
    output logic             overflow,
    output logic [1:0]       state_dbg
);

    localparam int TW = $clog2(DB_CYCLES + 1);
    localparam logic [TW-1:0] T_ONE  = TW'(1);
    // The sample that completes the run arrives while timer holds DB_CYCLES-1.
    localparam logic [TW-1:0] T_LAST = TW'(DB_CYCLES - 1);

    db_state_t     state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          level_q, level_d;
    logic          rise_q, rise_d;
    logic          fall_q, fall_d;

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        level_d = level_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        case (state_q)
            S_LOW: begin
                timer_d = '0;
                if (din) begin
                    if (DB_CYCLES == 1) begin
                        state_d = S_HIGH;
                        level_d = 1'b1;
                        rise_d  = 1'b1;
                    end else begin
                        state_d = P_HIGH;
                        timer_d = T_ONE;
                    end
                end
            end
            P_HIGH: begin
                if (!din) begin
                    state_d = S_LOW;
                    timer_d = '0;
                end else if (timer_q == T_LAST) begin
                    state_d = S_HIGH;
                    timer_d = '0;
                    level_d = 1'b1;
                    rise_d  = 1'b1;
                end else begin
                    timer_d = timer_q + T_ONE;
                end
            end
            S_HIGH: begin
                timer_d = '0;
                if (!din) begin
                    if (DB_CYCLES == 1) begin
                        state_d = S_LOW;
                        level_d = 1'b0;
                        fall_d  = 1'b1;
                    end else begin
                        state_d = P_LOW;
                        timer_d = T_ONE;
                    end
                end
            end
            P_LOW: begin
                if (din) begin
                    state_d = S_HIGH;
                    timer_d = '0;
                end else if (timer_q == T_LAST) begin
                    state_d = S_LOW;
                    timer_d = '0;
                    level_d = 1'b0;
                    fall_d  = 1'b1;
                end else begin
                    timer_d = timer_q + T_ONE;
                end
            end
            default: begin
                state_d = S_LOW;
                timer_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_LOW;
            timer_q <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    // rise_d drives the counter so count moves on the same edge as rise_pulse.
    sat_counter #(
        .CNT_W (CNT_W)
    ) u_sat_counter (
        .clk      (clk),
        .reset    (reset),
        .inc      (rise_d),
        .clear    (clear),
        .count    (count),
        .overflow (overflow)
    );

    assign level      = level_q;
    assign rise_pulse = rise_q;
    assign fall_pulse = fall_q;
    assign state_dbg  = state_q;

endmodule

// File: tb/tb_debounce_edge_counter.sv
module tb_debounce_edge_counter;

    logic       clk;
    logic       reset;
    logic       din;
    logic       clear;
    logic       level;
    logic       rise_pulse;
    logic       fall_pulse;
    logic [2:0] count;
    logic       overflow;
    logic [1:0] state_dbg;

    logic       din_b;
    logic       level_b;
    logic       rise_b;
    logic       fall_b;
    logic [7:0] count_b;
    logic       overflow_b;
    logic [1:0] state_b;

    int checks = 0;
    int errors = 0;

    debounce_edge_counter #(.DB_CYCLES(4), .CNT_W(3)) u_dut (
        .clk        (clk),
        .reset      (reset),
        .din        (din),
        .clear      (clear),
        .level      (level),
        .rise_pulse (rise_pulse),
        .fall_pulse (fall_pulse),
        .count      (count),
        .overflow   (overflow),
        .state_dbg  (state_dbg)
    );

    debounce_edge_counter #(.DB_CYCLES(1), .CNT_W(8)) u_dut_b (
        .clk        (clk),
        .reset      (reset),
        .din        (din_b),
        .clear      (1'b0),
        .level      (level_b),
        .rise_pulse (rise_b),
        .fall_pulse (fall_b),
        .count      (count_b),
        .overflow   (overflow_b),
        .state_dbg  (state_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Full clean pulse on the DB_CYCLES=4 instance, starting and ending low.
    task automatic rise_cycle(input int exp_cnt, input logic exp_ovf);
        din = 1'b1;
        repeat (3) begin
            step();
            chk("rise_early", {31'd0, rise_pulse}, 0);
        end
        step();
        chk("rise_pulse", {31'd0, rise_pulse}, 1);
        chk("rise_count", {29'd0, count}, exp_cnt);
        chk("rise_ovf", {31'd0, overflow}, {31'd0, exp_ovf});
        din = 1'b0;
        repeat (3) step();
        step();
        chk("fall_pulse_cyc", {31'd0, fall_pulse}, 1);
    endtask

    initial begin
        reset = 1'b0;
        din   = 1'b1;
        din_b = 1'b0;
        clear = 1'b0;

        // Reset held with din high: everything stays cleared.
        repeat (3) step();
        chk("rst_level", {31'd0, level}, 0);
        chk("rst_rise", {31'd0, rise_pulse}, 0);
        chk("rst_fall", {31'd0, fall_pulse}, 0);
        chk("rst_count", {29'd0, count}, 0);
        chk("rst_ovf", {31'd0, overflow}, 0);
        chk("rst_state", {30'd0, state_dbg}, 0);

        // Release with din already high: rise on the 4th edge.
        reset = 1'b1;
        repeat (3) begin
            step();
            chk("rel_level_low", {31'd0, level}, 0);
            chk("rel_no_rise", {31'd0, rise_pulse}, 0);
        end
        step();
        chk("rel_level", {31'd0, level}, 1);
        chk("rel_rise", {31'd0, rise_pulse}, 1);
        chk("rel_count", {29'd0, count}, 1);
        step();
        chk("rel_rise_one_cycle", {31'd0, rise_pulse}, 0);
        chk("rel_level_hold", {31'd0, level}, 1);

        // Fall after 4 low samples; count unchanged.
        din = 1'b0;
        repeat (3) begin
            step();
            chk("fall_level_hi", {31'd0, level}, 1);
            chk("fall_early", {31'd0, fall_pulse}, 0);
        end
        step();
        chk("fall_pulse", {31'd0, fall_pulse}, 1);
        chk("fall_level", {31'd0, level}, 0);
        chk("fall_count", {29'd0, count}, 1);
        step();
        chk("fall_one_cycle", {31'd0, fall_pulse}, 0);

        // Glitch of 3 samples is rejected.
        din = 1'b1;
        repeat (3) begin
            step();
            chk("glitch_rise", {31'd0, rise_pulse}, 0);
        end
        din = 1'b0;
        repeat (2) begin
            step();
            chk("glitch_level", {31'd0, level}, 0);
            chk("glitch_rise2", {31'd0, rise_pulse}, 0);
            chk("glitch_fall", {31'd0, fall_pulse}, 0);
        end
        chk("glitch_count", {29'd0, count}, 1);

        // Clean rises up to saturation of the 3-bit counter.
        for (int i = 2; i <= 7; i++) rise_cycle(i, 1'b0);
        rise_cycle(7, 1'b1);
        rise_cycle(7, 1'b1);

        // Clear alone.
        clear = 1'b1;
        step();
        clear = 1'b0;
        chk("clr_count", {29'd0, count}, 0);
        chk("clr_ovf", {31'd0, overflow}, 0);

        // Count to 5, then clear on the edge that accepts a rise.
        for (int i = 1; i <= 5; i++) rise_cycle(i, 1'b0);
        din = 1'b1;
        repeat (3) step();
        clear = 1'b1;
        step();
        clear = 1'b0;
        chk("coll_rise", {31'd0, rise_pulse}, 1);
        chk("coll_count", {29'd0, count}, 1);
        chk("coll_ovf", {31'd0, overflow}, 0);
        chk("coll_level", {31'd0, level}, 1);

        // Return low, then abort a pending rise with async reset.
        din = 1'b0;
        repeat (4) step();
        chk("pre_abort_level", {31'd0, level}, 0);
        din = 1'b1;
        repeat (2) step();
        chk("abort_state_phigh", {30'd0, state_dbg}, 1);
        chk("abort_count_pre", {29'd0, count}, 1);
        #3;
        reset = 1'b0;
        #1;
        chk("abort_count", {29'd0, count}, 0);
        chk("abort_state", {30'd0, state_dbg}, 0);
        chk("abort_level", {31'd0, level}, 0);
        chk("abort_rise", {31'd0, rise_pulse}, 0);
        step();
        step();
        din   = 1'b0;
        reset = 1'b1;
        repeat (6) begin
            step();
            chk("abort_no_rise", {31'd0, rise_pulse}, 0);
            chk("abort_level_low", {31'd0, level}, 0);
        end
        chk("abort_count_post", {29'd0, count}, 0);

        // DB_CYCLES=1: change accepted on the first sample.
        din_b = 1'b1;
        step();
        chk("b_rise", {31'd0, rise_b}, 1);
        chk("b_level", {31'd0, level_b}, 1);
        chk("b_count", {24'd0, count_b}, 1);
        step();
        chk("b_rise_one_cycle", {31'd0, rise_b}, 0);
        din_b = 1'b0;
        step();
        chk("b_fall", {31'd0, fall_b}, 1);
        chk("b_level_low", {31'd0, level_b}, 0);
        step();
        chk("b_fall_one_cycle", {31'd0, fall_b}, 0);
        chk("b_ovf", {31'd0, overflow_b}, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
